// File: rtl/bp_be_irf_wb_arbiter_if.sv
// Writeback arbiter bundle: pipe, long-latency and cfg write sources plus the regfile write port.
// Latency: none, this is a signal bundle only.
// Backpressure: long_ready_o / cfg_ready_o gate the requesters; the pipe obeys stall_pipe_o.
// Ports: master = requester/regfile side, slave = bp_be_irf_wb_arbiter.
interface bp_be_irf_wb_arbiter_if #(
  parameter int dword_width_p    = 64,
  parameter int reg_addr_width_p = 5
);
  logic                        pipe_w_v_i;
  logic [reg_addr_width_p-1:0] pipe_addr_i;
  logic [dword_width_p-1:0]    pipe_data_i;
  logic                        long_v_i;
  logic                        long_ready_o;
  logic [reg_addr_width_p-1:0] long_addr_i;
  logic [dword_width_p-1:0]    long_data_i;
  logic                        cfg_w_v_i;
  logic                        cfg_ready_o;
  logic [reg_addr_width_p-1:0] cfg_addr_i;
  logic [dword_width_p-1:0]    cfg_data_i;
  logic                        stall_pipe_o;
  logic                        long_pending_o;
  logic                        rd_w_v_o;
  logic [reg_addr_width_p-1:0] rd_addr_o;
  logic [dword_width_p-1:0]    rd_data_o;

  modport master (
    output pipe_w_v_i, pipe_addr_i, pipe_data_i,
           long_v_i, long_addr_i, long_data_i,
           cfg_w_v_i, cfg_addr_i, cfg_data_i,
    input  long_ready_o, cfg_ready_o, stall_pipe_o, long_pending_o,
           rd_w_v_o, rd_addr_o, rd_data_o
  );

  modport slave (
    input  pipe_w_v_i, pipe_addr_i, pipe_data_i,
           long_v_i, long_addr_i, long_data_i,
           cfg_w_v_i, cfg_addr_i, cfg_data_i,
    output long_ready_o, cfg_ready_o, stall_pipe_o, long_pending_o,
           rd_w_v_o, rd_addr_o, rd_data_o
  );
endinterface

// File: rtl/bp_be_irf_wb_arbiter.sv
// Shares the integer regfile write port: pipe > long-latency FIFO head > cfg write.
// Latency: pipe 0 cycles (combinational); long-latency >= 1 cycle after accept; cfg in grant cycle.
// Backpressure: long_ready_o when FIFO has room, cfg_ready_o only when pipe idle and FIFO empty.
// Ports: clk_i, reset_i (async, active-high) plus the wb slave modport (see the interface file).
// Optional: define BP_BE_WB_ARB_STARVE_EN to build the starvation counter that raises
// stall_pipe_o for one cycle so a blocked FIFO head is guaranteed to drain.
module bp_be_irf_wb_arbiter #(
  parameter int dword_width_p    = 64,
  parameter int reg_addr_width_p = 5,
  parameter int buf_els_p        = 2,
  parameter int starve_limit_p   = 8
) (
  input logic                   clk_i,
  input logic                   reset_i,
  bp_be_irf_wb_arbiter_if.slave wb
);

  localparam int ptr_w_lp = (buf_els_p > 1) ? $clog2(buf_els_p) : 1;
  localparam int cnt_w_lp = $clog2(buf_els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(buf_els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(buf_els_p);

  if ((buf_els_p < 1) || (starve_limit_p < 2)) begin : g_param_check
    $error("bp_be_irf_wb_arbiter: buf_els_p must be >= 1 and starve_limit_p >= 2");
  end

  // Long-latency FIFO storage
  logic [dword_width_p-1:0]    buf_data_q [buf_els_p];
  logic [dword_width_p-1:0]    buf_data_d [buf_els_p];
  logic [reg_addr_width_p-1:0] buf_addr_q [buf_els_p];
  logic [reg_addr_width_p-1:0] buf_addr_d [buf_els_p];
  logic [ptr_w_lp-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]         count_q, count_d;

  logic fifo_empty, enq, deq, cfg_grant;
  logic                        grant_v;
  logic [reg_addr_width_p-1:0] grant_addr;
  logic [dword_width_p-1:0]    grant_data;

  assign fifo_empty = (count_q == '0);
  // Ready is taken from the registered count only, so a full FIFO never
  // accepts even when the head is draining this cycle.
  assign wb.long_ready_o   = ~reset_i & (count_q < full_cnt_lp);
  assign enq               = wb.long_v_i & wb.long_ready_o;
  // The head only reads registered storage, so an entry accepted this cycle
  // cannot leave before the next one.
  assign deq               = ~wb.pipe_w_v_i & ~fifo_empty;
  assign cfg_grant         = wb.cfg_w_v_i & ~wb.pipe_w_v_i & fifo_empty;
  assign wb.cfg_ready_o    = ~reset_i & cfg_grant;
  assign wb.long_pending_o = ~reset_i & ~fifo_empty;

  always_comb begin
    grant_v    = 1'b0;
    grant_addr = '0;
    grant_data = '0;
    if (wb.pipe_w_v_i) begin
      grant_v    = 1'b1;
      grant_addr = wb.pipe_addr_i;
      grant_data = wb.pipe_data_i;
    end else if (deq) begin
      grant_v    = 1'b1;
      grant_addr = buf_addr_q[rd_ptr_q];
      grant_data = buf_data_q[rd_ptr_q];
    end else if (cfg_grant) begin
      grant_v    = 1'b1;
      grant_addr = wb.cfg_addr_i;
      grant_data = wb.cfg_data_i;
    end
  end

  // x0 writes still consume the slot; only the write enable is suppressed.
  assign wb.rd_w_v_o  = ~reset_i & grant_v & (grant_addr != '0);
  assign wb.rd_addr_o = reset_i ? '0 : grant_addr;
  assign wb.rd_data_o = reset_i ? '0 : grant_data;

  always_comb begin
    buf_data_d = buf_data_q;
    buf_addr_d = buf_addr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (enq) begin
      buf_data_d[wr_ptr_q] = wb.long_data_i;
      buf_addr_d[wr_ptr_q] = wb.long_addr_i;
      wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + 1'b1;
    end
    if (deq) begin
      rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < buf_els_p; i++) begin
        buf_data_q[i] <= '0;
        buf_addr_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      buf_data_q <= buf_data_d;
      buf_addr_q <= buf_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

`ifdef BP_BE_WB_ARB_STARVE_EN
  localparam logic [0:0] state_idle_lp  = 1'b0;
  localparam logic [0:0] state_steal_lp = 1'b1;
  localparam int starve_w_lp = $clog2(starve_limit_p);
  localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p - 1);

  logic [0:0]             state_q, state_d;
  logic [starve_w_lp-1:0] starve_cnt_q, starve_cnt_d;
  logic                   head_blocked;

  assign head_blocked = ~fifo_empty & wb.pipe_w_v_i;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if (state_q == state_idle_lp) begin
      if (deq) begin
        starve_cnt_d = '0;
      end else if (head_blocked) begin
        if (starve_cnt_q == starve_max_lp) begin
          state_d      = state_steal_lp;
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = starve_cnt_q + 1'b1;
        end
      end
    end else if (deq) begin
      // Stolen slot used by the head. If the pipe wrote anyway we stay here
      // and steal again next cycle.
      state_d      = state_idle_lp;
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= state_idle_lp;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign wb.stall_pipe_o = (state_q == state_steal_lp);

  steal_pipe_idle_a: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == state_steal_lp) |-> !wb.pipe_w_v_i);
`else
  assign wb.stall_pipe_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_be_irf_wb_arbiter.sv
// Directed bench for bp_be_irf_wb_arbiter (buf_els_p=2, starve_limit_p=8).
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
// Expectations for the starvation case depend on BP_BE_WB_ARB_STARVE_EN.
module tb_bp_be_irf_wb_arbiter;
  localparam int dw = 64;
  localparam int aw = 5;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  logic found;

  bp_be_irf_wb_arbiter_if #(.dword_width_p(dw), .reg_addr_width_p(aw)) wb ();

  bp_be_irf_wb_arbiter #(
    .dword_width_p(dw), .reg_addr_width_p(aw), .buf_els_p(2), .starve_limit_p(8)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .wb     (wb)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_rd(input string tag, input logic v, input logic [aw-1:0] a,
                          input logic [dw-1:0] d);
    check({tag, "_v"}, wb.rd_w_v_o, v);
    if (v) begin
      check({tag, "_addr"}, wb.rd_addr_o, a);
      check({tag, "_data"}, wb.rd_data_o, d);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [aw-1:0] pa, input logic [dw-1:0] pd,
                       input logic lv, input logic [aw-1:0] la, input logic [dw-1:0] ld);
    wb.pipe_w_v_i  = pv;
    wb.pipe_addr_i = pa;
    wb.pipe_data_i = pd;
    wb.long_v_i    = lv;
    wb.long_addr_i = la;
    wb.long_data_i = ld;
    #1;
  endtask

  task automatic set_cfg(input logic cv, input logic [aw-1:0] ca, input logic [dw-1:0] cd);
    wb.cfg_w_v_i  = cv;
    wb.cfg_addr_i = ca;
    wb.cfg_data_i = cd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // Reset held, requests active: every output must be gated to 0.
    set_cfg(1, 7, 64'h55);
    drive(1, 5, 64'hA, 1, 6, 64'hB);
    #1;
    check("rst_rd_v", wb.rd_w_v_o, 0);
    check("rst_rd_addr", wb.rd_addr_o, 0);
    check("rst_long_rdy", wb.long_ready_o, 0);
    check("rst_cfg_rdy", wb.cfg_ready_o, 0);
    check("rst_stall", wb.stall_pipe_o, 0);
    check("rst_pend", wb.long_pending_o, 0);
    step();
    step();
    reset_i = 1'b0;
    set_cfg(0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("post_rst_rdy", wb.long_ready_o, 1);
    check("post_rst_stall", wb.stall_pipe_o, 0);
    check("post_rst_pend", wb.long_pending_o, 0);

    // Pipe and long in the same cycle: pipe now, long one cycle later.
    step(); drive(1, 5, 64'hA, 1, 6, 64'hB);
    check_rd("t1_pipe", 1, 5, 64'hA);
    check("t1_rdy", wb.long_ready_o, 1);
    step(); drive(0, 0, 0, 0, 0, 0);
    check_rd("t1_long", 1, 6, 64'hB);
    check("t1_pend", wb.long_pending_o, 1);
    step(); drive(0, 0, 0, 0, 0, 0);
    check_rd("t1_idle", 0, 0, 0);
    check("t1_pend_clr", wb.long_pending_o, 0);

    // Fill the FIFO behind a busy pipe, then drain in order.
    step(); drive(1, 3, 64'h33, 1, 1, 64'h1);
    check("t2_rdy0", wb.long_ready_o, 1);
    step(); drive(1, 3, 64'h33, 1, 2, 64'h2);
    check("t2_rdy1", wb.long_ready_o, 1);
    check_rd("t2_pipe", 1, 3, 64'h33);
    step(); drive(1, 3, 64'h33, 0, 0, 0);
    check("t2_full", wb.long_ready_o, 0);
    check("t2_pend", wb.long_pending_o, 1);
    step(); drive(0, 0, 0, 0, 0, 0);
    check_rd("t2_first", 1, 1, 64'h1);
    check("t2_full_drain", wb.long_ready_o, 0);
    step(); drive(0, 0, 0, 0, 0, 0);
    check_rd("t2_second", 1, 2, 64'h2);
    check("t2_rdy_back", wb.long_ready_o, 1);
    step(); drive(0, 0, 0, 0, 0, 0);
    check("t2_empty", wb.long_pending_o, 0);

    // Starvation: one buffered result behind continuous pipe traffic.
    step(); drive(1, 3, 64'h33, 1, 4, 64'h44);
    check("t3_enq_rdy", wb.long_ready_o, 1);
    for (int k = 0; k < 10; k++) begin
      step();
      drive(!wb.stall_pipe_o, 3, 64'h33, 0, 0, 0);
`ifdef BP_BE_WB_ARB_STARVE_EN
      check("t3_stall", wb.stall_pipe_o, (k == 8));
      check("t3_pend", wb.long_pending_o, (k <= 8));
      if (k == 8) check_rd("t3_steal", 1, 4, 64'h44);
`else
      check("t3_stall", wb.stall_pipe_o, 0);
      check("t3_pend", wb.long_pending_o, 1);
`endif
    end
    step(); drive(0, 0, 0, 0, 0, 0);
`ifdef BP_BE_WB_ARB_STARVE_EN
    check_rd("t3_after", 0, 0, 0);
`else
    check_rd("t3_idle_drain", 1, 4, 64'h44);
`endif

    // Cfg waits for an empty FIFO and idle pipe; x0 head consumes a slot silently.
    step(); drive(1, 3, 64'h33, 1, 0, 64'h99);
    set_cfg(1, 7, 64'h55); #1;
    check("t4_cfg_pipe", wb.cfg_ready_o, 0);
    step(); drive(0, 0, 0, 0, 0, 0);
    check("t4_cfg_fifo", wb.cfg_ready_o, 0);
    check("t4_x0_v", wb.rd_w_v_o, 0);
    check("t4_x0_pend", wb.long_pending_o, 1);
    step(); drive(0, 0, 0, 0, 0, 0);
    check("t4_cfg_grant", wb.cfg_ready_o, 1);
    check_rd("t4_cfg", 1, 7, 64'h55);
    set_cfg(0, 0, 0);
    step(); drive(0, 0, 0, 0, 0, 0);
    check_rd("t4_idle", 0, 0, 0);

    // Reset with the FIFO full (and mid-steal when the counter is built).
    step(); drive(1, 3, 64'h33, 1, 1, 64'h1);
    step(); drive(1, 3, 64'h33, 1, 2, 64'h2);
`ifdef BP_BE_WB_ARB_STARVE_EN
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      drive(!wb.stall_pipe_o, 3, 64'h33, 0, 0, 0);
      if (wb.stall_pipe_o) found = 1'b1;
    end
    check("t5_steal_seen", found, 1);
`else
    step(); drive(1, 3, 64'h33, 0, 0, 0);
`endif
    check("t5_full", wb.long_ready_o, 0);
    check("t5_pend", wb.long_pending_o, 1);
    set_cfg(1, 7, 64'h55);
    wb.pipe_w_v_i = 1'b1;
    reset_i = 1'b1;
    #1;
    check("t5_rst_rd_v", wb.rd_w_v_o, 0);
    check("t5_rst_rd_data", wb.rd_data_o, 0);
    check("t5_rst_rdy", wb.long_ready_o, 0);
    check("t5_rst_cfg", wb.cfg_ready_o, 0);
    check("t5_rst_stall", wb.stall_pipe_o, 0);
    check("t5_rst_pend", wb.long_pending_o, 0);
    step();
    step();
    reset_i = 1'b0;
    set_cfg(0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("t5_rel_rdy", wb.long_ready_o, 1);
    check("t5_rel_pend", wb.long_pending_o, 0);
    check("t5_rel_stall", wb.stall_pipe_o, 0);
    check("t5_rel_rd_v", wb.rd_w_v_o, 0);
    step(); drive(0, 0, 0, 0, 0, 0);
    check("t5_no_drain", wb.rd_w_v_o, 0);
    check("t5_still_empty", wb.long_pending_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
